// File: rtl/lc3_mem_sequencer.sv
// rtl/lc3_mem_sequencer.sv - LC3 data-memory access sequencer driving MAR_LE/MAR_CONTROL/WE and capturing MDR
// Optional 12-bit address bounds checking is enabled by defining LC3_MEM_BOUNDS_EN.
module lc3_mem_sequencer #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic [2:0]  OP,
  input  logic [15:0] Y,
  input  logic [15:0] DATA,
  output logic        MAR_LE,
  output logic        MAR_CONTROL,
  output logic        WE,
  output logic [15:0] MDR,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  localparam logic [2:0] OP_LDI = 3'd2;
  localparam logic [2:0] OP_ST  = 3'd3;
  localparam logic [2:0] OP_STI = 3'd4;

  localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        ind_q, ind_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] mdr_q, mdr_d;
  logic        err_q, err_d;

  logic op_rsvd;
  logic op_ind;
  logic ind_pass;
  logic y_fault;
  logic data_fault;
  logic unused_y;

  assign op_rsvd  = (op_q > OP_STI);
  assign op_ind   = (op_q == OP_LDI) || (op_q == OP_STI);
  // First READ of an indirect op fetches the pointer rather than the result.
  assign ind_pass = (state_q == S_READ) && op_ind && !ind_q;

`ifdef LC3_MEM_BOUNDS_EN
  assign y_fault    = |Y[15:12];
  assign data_fault = |DATA[15:12];
`else
  assign y_fault    = 1'b0;
  assign data_fault = 1'b0;
`endif

  // Y reaches MAR directly in the memory stage; here it only feeds the bounds check.
  assign unused_y = ^Y;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ind_d   = ind_q;
    cnt_d   = cnt_q;
    mdr_d   = mdr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          op_d    = OP;
          ind_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (op_rsvd) begin
          state_d = S_FIN;
        end else if (y_fault) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (op_q == OP_ST) begin
          state_d = S_WRITE;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_READ: begin
        if (ind_pass) begin
          if (data_fault) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            ind_d = 1'b1;
            if (op_q == OP_LDI) begin
              cnt_d   = WAIT_INIT;
              state_d = S_WAIT;
            end else begin
              state_d = S_WRITE;
            end
          end
        end else begin
          mdr_d   = DATA;
          state_d = S_FIN;
        end
      end
      S_WRITE: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      ind_q   <= 1'b0;
      cnt_q   <= 3'd0;
      mdr_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ind_q   <= ind_d;
      cnt_q   <= cnt_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
    end
  end

  // Without bounds checking both fault terms are constant 0, so ERR reduces to 0.
  assign MAR_LE      = ((state_q == S_ADDR) && !op_rsvd && !y_fault) ||
                       (ind_pass && !data_fault);
  assign MAR_CONTROL = ind_pass && !data_fault;
  assign WE          = (state_q == S_WRITE);
  assign BUSY        = (state_q != S_IDLE);
  assign DONE        = (state_q == S_FIN);
  assign ERR         = (state_q == S_FIN) && err_q;
  assign MDR         = mdr_q;

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// tb/tb_lc3_mem_sequencer.sv - self-checking bench for lc3_mem_sequencer (READ_LAT=1 and READ_LAT=3 instances)
module tb_lc3_mem_sequencer;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
`ifdef LC3_MEM_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [15:0] y;
    logic [15:0] wd;
    int          cyc;
    int          le_n;
    int          we_n;
    logic        err;
    logic [15:0] mdr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [2:0]  op;
  logic [15:0] y, rd_data;
  logic        req_a, req_b, sel;
  logic [15:0] data_a, data_b, mdr_a, mdr_b;
  logic        le_a, ctl_a, we_a, busy_a, done_a, err_a;
  logic        le_b, ctl_b, we_b, busy_b, done_b, err_b;

  logic [15:0] mem [4096];
  logic [15:0] ref_mem [4096];
  logic [15:0] mar_a = 16'd0, mar_b = 16'd0;
  int          lat_a = 0, lat_b = 0;
  logic        pk_en = 1'b0;
  logic [11:0] pk_addr = 12'd0;
  logic [15:0] pk_val = 16'd0;
  logic [15:0] ref_mdr_a, ref_mdr_b;
  int          n_cmp = 0, n_bad = 0;

  lc3_mem_sequencer #(.READ_LAT(LAT_A)) u_dut_a (
    .CLK(clk), .RESET(rst), .REQ(req_a), .OP(op), .Y(y), .DATA(data_a),
    .MAR_LE(le_a), .MAR_CONTROL(ctl_a), .WE(we_a), .MDR(mdr_a),
    .BUSY(busy_a), .DONE(done_a), .ERR(err_a)
  );

  lc3_mem_sequencer #(.READ_LAT(LAT_B)) u_dut_b (
    .CLK(clk), .RESET(rst), .REQ(req_b), .OP(op), .Y(y), .DATA(data_b),
    .MAR_LE(le_b), .MAR_CONTROL(ctl_b), .WE(we_b), .MDR(mdr_b),
    .BUSY(busy_b), .DONE(done_b), .ERR(err_b)
  );

  // Memory stage model: MAR register plus DRAM whose output is garbage until READ_LAT cycles after a MAR update.
  always @(posedge clk) begin
    if (pk_en) mem[pk_addr] <= pk_val;
    if (we_a) mem[mar_a[11:0]] <= rd_data;
    if (we_b) mem[mar_b[11:0]] <= rd_data;
    if (le_a) begin
      mar_a <= ctl_a ? data_a : y;
      lat_a <= 0;
    end else if (lat_a < 15) lat_a <= lat_a + 1;
    if (le_b) begin
      mar_b <= ctl_b ? data_b : y;
      lat_b <= 0;
    end else if (lat_b < 15) lat_b <= lat_b + 1;
  end
  assign data_a = (lat_a >= LAT_A) ? mem[mar_a[11:0]] : ~mem[mar_a[11:0]];
  assign data_b = (lat_b >= LAT_B) ? mem[mar_b[11:0]] : ~mem[mar_b[11:0]];

  logic s_le, s_ctl, s_we, s_busy, s_done, s_err;
  logic [15:0] s_mdr;
  assign s_le   = sel ? le_b   : le_a;
  assign s_ctl  = sel ? ctl_b  : ctl_a;
  assign s_we   = sel ? we_b   : we_a;
  assign s_busy = sel ? busy_b : busy_a;
  assign s_done = sel ? done_b : done_a;
  assign s_err  = sel ? err_b  : err_a;
  assign s_mdr  = sel ? mdr_b  : mdr_a;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_req(input logic v);
    if (sel) req_b = v;
    else req_a = v;
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] v);
    @(negedge clk);
    pk_en = 1'b1; pk_addr = a; pk_val = v; ref_mem[a] = v;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  function automatic bit fault(input logic [15:0] a);
    return BOUNDS && (a[15:12] != 4'd0);
  endfunction

  // Reference: outcome of one access computed directly from the access rules.
  task automatic ref_access(input logic [2:0] o, input logic [15:0] a, input logic [15:0] w, input int lat,
                            inout logic [15:0] mdr, output int cyc, output int le_n, output int we_n,
                            output logic err, output int waddr);
    logic [15:0] ptr;
    err = 1'b0; le_n = 0; we_n = 0; waddr = -1; cyc = 2;
    if (o > 3'd4) return;
    if (fault(a)) begin
      err = 1'b1;
      return;
    end
    le_n = 1;
    if (o == 3'd3) begin
      cyc = 3; we_n = 1; waddr = int'(a[11:0]); ref_mem[a[11:0]] = w;
    end else if (o <= 3'd1) begin
      cyc = 3 + lat; mdr = ref_mem[a[11:0]];
    end else begin
      ptr = ref_mem[a[11:0]];
      if (fault(ptr)) begin
        cyc = 3 + lat; err = 1'b1;
      end else if (o == 3'd2) begin
        le_n = 2; cyc = 4 + 2 * lat; mdr = ref_mem[ptr[11:0]];
      end else begin
        le_n = 2; cyc = 4 + lat; we_n = 1; waddr = int'(ptr[11:0]); ref_mem[ptr[11:0]] = w;
      end
    end
  endtask

  task automatic do_check(input string tag, input logic [2:0] o, input logic [15:0] a, input logic [15:0] w,
                          input int ecyc, input int ele, input int ewe, input logic eerr, input logic [15:0] emdr);
    int cyc, le_n, we_n, ctl_n, le_first, we_cyc;
    logic err_seen, busy_ok, stray;
    cyc = 0; le_n = 0; we_n = 0; ctl_n = 0; le_first = 0; we_cyc = 0;
    err_seen = 1'b0; busy_ok = 1'b1; stray = 1'b0;
    @(negedge clk);
    op = o; y = a; rd_data = w; set_req(1'b1);
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        set_req(1'b0);
        op = 3'($urandom);
      end
      if (!s_busy) busy_ok = 1'b0;
      if (s_le) begin
        le_n++;
        if (le_first == 0) le_first = k;
        if (s_ctl) ctl_n++;
      end
      if (s_we) begin
        we_n++; we_cyc = k;
      end
      if (s_done) begin
        cyc = k; err_seen = s_err;
        break;
      end
      if (s_err) stray = 1'b1;
    end
    chk({tag, "_done_cycle"}, cyc, ecyc);
    chk({tag, "_mar_le_count"}, le_n, ele);
    chk({tag, "_we_count"}, we_n, ewe);
    chk({tag, "_mar_ctl_count"}, ctl_n, (ele == 2) ? 1 : 0);
    if (ele > 0) chk({tag, "_mar_le_first"}, le_first, 1);
    if (ewe > 0) chk({tag, "_we_cycle"}, we_cyc, ecyc - 1);
    chk({tag, "_err"}, err_seen, eerr);
    chk({tag, "_err_outside_fin"}, stray, 1'b0);
    chk({tag, "_mdr"}, s_mdr, emdr);
    chk({tag, "_busy_held"}, busy_ok, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, {s_busy, s_done, s_err}, 3'b000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    logic [15:0] m, v;
    int ecyc, ele, ewe, wa, prev, ndone, nidle;
    logic eerr;

    req_a = 1'b0; req_b = 1'b0; sel = 1'b0; op = 3'd0; y = 16'd0; rd_data = 16'd0;
    ref_mdr_a = 16'd0; ref_mdr_b = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs_a", {ctl_a, le_a, we_a, busy_a, done_a, err_a, mdr_a}, 32'd0);
    chk("reset_outputs_b", {ctl_b, le_b, we_b, busy_b, done_b, err_b, mdr_b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4096; i++) begin
      v = 16'($urandom);
      if (BOUNDS && $urandom_range(0, 3) != 0) v[15:12] = 4'd0;
      poke(12'(i), v);
    end
    poke(12'h010, 16'hBEEF);
    poke(12'h030, 16'h0040);
    poke(12'h040, 16'hCAFE);

    tbl[0] = '{3'd1, 16'h0010, 16'h0000, 4, 1, 0, 1'b0, 16'hBEEF};
    tbl[1] = '{3'd3, 16'h0020, 16'h1234, 3, 1, 1, 1'b0, 16'hBEEF};
    tbl[2] = '{3'd1, 16'h0020, 16'h0000, 4, 1, 0, 1'b0, 16'h1234};
    tbl[3] = '{3'd2, 16'h0030, 16'h0000, 6, 2, 0, 1'b0, 16'hCAFE};
    tbl[4] = '{3'd4, 16'h0030, 16'h5A5A, 5, 2, 1, 1'b0, 16'hCAFE};
    tbl[5] = '{3'd1, 16'h0040, 16'h0000, 4, 1, 0, 1'b0, 16'h5A5A};
    tbl[6] = '{3'd7, 16'h0010, 16'h0000, 2, 0, 0, 1'b0, 16'h5A5A};
    tbl[7] = '{3'd0, 16'h0010, 16'h0000, 4, 1, 0, 1'b0, 16'hBEEF};
    tbl[8] = '{3'd1, 16'h0040, 16'h0000, 4, 1, 0, 1'b0, 16'h5A5A};
    if (BOUNDS) tbl[9] = '{3'd1, 16'h1010, 16'h0000, 2, 0, 0, 1'b1, 16'h5A5A};
    else tbl[9] = '{3'd1, 16'h1010, 16'h0000, 4, 1, 0, 1'b0, 16'hBEEF};

    sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      m = ref_mdr_a;
      ref_access(tbl[i].op, tbl[i].y, tbl[i].wd, LAT_A, m, ecyc, ele, ewe, eerr, wa);
      ref_mdr_a = m;
      do_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].y, tbl[i].wd,
               tbl[i].cyc, tbl[i].le_n, tbl[i].we_n, tbl[i].err, tbl[i].mdr);
      if (wa >= 0) chk($sformatf("vec%0d_mem", i), mem[wa], ref_mem[wa]);
    end
    do_check("rsvd6", 3'd6, 16'h1010, 16'h0000, 2, 0, 0, 1'b0, ref_mdr_a);

    // Reset in the middle of a store: WE must drop at once and no DONE may follow.
    @(negedge clk);
    op = 3'd3; y = 16'h0050; rd_data = ~ref_mem[12'h050]; req_a = 1'b1;
    @(posedge clk); #1;
    req_a = 1'b0;
    @(posedge clk); #1;
    chk("rst_st_we_before", we_a, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_st_async", {we_a, busy_a, done_a, mdr_a}, 19'd0);
    chk("rst_st_mdr_b", mdr_b, 16'd0);
    ndone = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done_a) ndone++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done_a || busy_a) ndone++;
    end
    chk("rst_st_no_done", ndone, 0);
    chk("rst_st_mem_untouched", mem[12'h050], ref_mem[12'h050]);
    ref_mdr_a = 16'd0; ref_mdr_b = 16'd0;

    // REQ held high with back-to-back loads on the READ_LAT=3 instance.
    sel = 1'b1;
    y = 16'h0077;
    m = ref_mdr_b;
    ref_access(3'd1, 16'h0077, 16'h0000, LAT_B, m, ecyc, ele, ewe, eerr, wa);
    ref_mdr_b = m;
    @(negedge clk);
    op = 3'd1; req_b = 1'b1;
    prev = 0; ndone = 0; nidle = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done_b) begin
        if (ndone == 0) chk("b2b_first_done", k, 3 + LAT_B);
        else chk($sformatf("b2b_gap%0d", ndone), k - prev, 7);
        chk($sformatf("b2b_mdr%0d", ndone), mdr_b, ref_mdr_b);
        prev = k;
        ndone++;
      end
      if (!busy_b) nidle++;
    end
    chk("b2b_done_count", ndone, 4);
    chk("b2b_idle_cycles", nidle, 4);
    @(negedge clk);
    req_b = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20 && busy_b; k++) begin
      @(posedge clk); #1;
      ndone++;
    end
    chk("b2b_drained", busy_b, 1'b0);

    for (int t = 0; t < 300; t++) begin
      logic [2:0] o;
      logic [15:0] a, w;
      sel = 1'($urandom_range(0, 1));
      o = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      w = 16'($urandom);
      if (BOUNDS && $urandom_range(0, 3) != 0) a[15:12] = 4'd0;
      m = sel ? ref_mdr_b : ref_mdr_a;
      ref_access(o, a, w, sel ? LAT_B : LAT_A, m, ecyc, ele, ewe, eerr, wa);
      if (sel) ref_mdr_b = m;
      else ref_mdr_a = m;
      do_check($sformatf("rnd%0d", t), o, a, w, ecyc, ele, ewe, eerr, m);
      if (wa >= 0) chk($sformatf("rnd%0d_mem", t), mem[wa], ref_mem[wa]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
